// File: rtl/i2s_tx_ctrl.sv
// I2S transmit frame sequencer: single-entry stereo sample buffer feeding
// 64-clock frames (two 32-bit slots, left-justified data, WS one bit early).
module i2s_tx_ctrl #(
  parameter int DATA_W = 16
) (
  input  logic              i_tclk,
  input  logic              i_nrst,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_ws,
  output logic              o_sd,
  output logic              o_busy,
  output logic              o_underrun,
  input  logic              i_clr_underrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [5:0]        pos_r, pos_s;
  logic              buf_full_r, buf_full_s;
  logic [DATA_W-1:0] buf_left_r, buf_right_r;
  logic [DATA_W-1:0] sh_left_r, sh_right_r, sh_left_s, sh_right_s;
  logic              ws_r, ws_s, sd_r, sd_s;
  logic              busy_r, ready_r, ready_s;
  logic              underrun_r, underrun_s;
  logic              accept_s, drain_s, ur_set_s;
  logic [31:0]       slot_l_s, slot_r_s;
  logic [4:0]        bit_idx_s;

  assign accept_s = i_valid && !buf_full_r;

  // Next-state, frame position and shift-register load selection
  always_comb begin
    state_s    = state_r;
    pos_s      = pos_r;
    sh_left_s  = sh_left_r;
    sh_right_s = sh_right_r;
    drain_s    = 1'b0;
    ur_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pos_s = 6'd0;
        if (i_enable) begin
          state_s = ST_ARM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        pos_s = 6'd0;
        if (!i_enable) begin
          state_s = ST_IDLE;
        end else if (buf_full_r) begin
          state_s    = ST_RUN;
          sh_left_s  = buf_left_r;
          sh_right_s = buf_right_r;
          drain_s    = 1'b1;
        end else begin
          state_s = ST_ARM;
        end
      end
      ST_RUN: begin
        if (pos_r == 6'd63) begin
          pos_s = 6'd0;
          if (!i_enable) begin
            state_s = ST_IDLE;
          end else if (buf_full_r) begin
            sh_left_s  = buf_left_r;
            sh_right_s = buf_right_r;
            drain_s    = 1'b1;
          end else begin
            // no sample ready: transmit the frame as silence
            sh_left_s  = {DATA_W{1'b0}};
            sh_right_s = {DATA_W{1'b0}};
            ur_set_s   = 1'b1;
          end
        end else begin
          pos_s = pos_r + 6'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pos_s   = 6'd0;
      end
    endcase
  end

  // Serial outputs, buffer occupancy and sticky underrun for the coming period
  always_comb begin
    slot_l_s  = 32'(sh_left_s) << (32 - DATA_W);
    slot_r_s  = 32'(sh_right_s) << (32 - DATA_W);
    bit_idx_s = ~pos_s[4:0];
    if (state_s == ST_RUN) begin
      sd_s = pos_s[5] ? slot_r_s[bit_idx_s] : slot_l_s[bit_idx_s];
      ws_s = (pos_s >= 6'd31) && (pos_s <= 6'd62);
    end else begin
      sd_s = 1'b0;
      ws_s = 1'b0;
    end
    if (accept_s) begin
      buf_full_s = 1'b1;
    end else if (drain_s) begin
      buf_full_s = 1'b0;
    end else begin
      buf_full_s = buf_full_r;
    end
    ready_s = !buf_full_s;
    if (ur_set_s) begin
      underrun_s = 1'b1;
    end else if (i_clr_underrun) begin
      underrun_s = 1'b0;
    end else begin
      underrun_s = underrun_r;
    end
  end

  // State and datapath registers, all on the falling bit-clock edge
  always_ff @(negedge i_tclk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_r     <= ST_IDLE;
      pos_r       <= 6'd0;
      buf_full_r  <= 1'b0;
      buf_left_r  <= {DATA_W{1'b0}};
      buf_right_r <= {DATA_W{1'b0}};
      sh_left_r   <= {DATA_W{1'b0}};
      sh_right_r  <= {DATA_W{1'b0}};
      ws_r        <= 1'b0;
      sd_r        <= 1'b0;
      busy_r      <= 1'b0;
      ready_r     <= 1'b1;
      underrun_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      pos_r      <= pos_s;
      buf_full_r <= buf_full_s;
      if (accept_s) begin
        buf_left_r  <= i_left;
        buf_right_r <= i_right;
      end
      sh_left_r  <= sh_left_s;
      sh_right_r <= sh_right_s;
      ws_r       <= ws_s;
      sd_r       <= sd_s;
      busy_r     <= (state_s != ST_IDLE);
      ready_r    <= ready_s;
      underrun_r <= underrun_s;
    end
  end

  assign o_ready    = ready_r;
  assign o_ws       = ws_r;
  assign o_sd       = sd_r;
  assign o_busy     = busy_r;
  assign o_underrun = underrun_r;

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed bench for i2s_tx_ctrl: frames, back-to-back feed, underrun,
// stop, ARM abort and asynchronous reset mid-frame.
module tb_i2s_tx_ctrl;
  localparam int DW = 16;

  logic          i_tclk = 1'b1;
  logic          i_nrst = 1'b0;
  logic          i_enable = 1'b0;
  logic [DW-1:0] i_left = '0;
  logic [DW-1:0] i_right = '0;
  logic          i_valid = 1'b0;
  logic          o_ready, o_ws, o_sd, o_busy, o_underrun;
  logic          i_clr_underrun = 1'b0;

  int checks = 0;
  int errors = 0;

  i2s_tx_ctrl #(.DATA_W(DW)) dut (
    .i_tclk        (i_tclk),
    .i_nrst        (i_nrst),
    .i_enable      (i_enable),
    .i_left        (i_left),
    .i_right       (i_right),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .o_ws          (o_ws),
    .o_sd          (o_sd),
    .o_busy        (o_busy),
    .o_underrun    (o_underrun),
    .i_clr_underrun(i_clr_underrun)
  );

  always #5 i_tclk = ~i_tclk;

  task automatic tick();
    @(negedge i_tclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered just after the edge that starts pos 0; returns observing pos 63.
  task automatic check_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input logic exp_ur, input int clr_at, input int drop_at,
                             input logic feed, input logic [DW-1:0] nl,
                             input logic [DW-1:0] nr);
    for (int p = 0; p < 64; p++) begin
      logic e_sd, e_ws, e_ur;
      if (p > 0) tick();
      e_sd = 1'b0;
      if (p < DW) e_sd = l[DW-1-p];
      else if (p >= 32 && p < 32 + DW) e_sd = r[DW-1-(p-32)];
      e_ws = (p >= 31 && p <= 62);
      e_ur = (clr_at >= 0 && p > clr_at) ? 1'b0 : exp_ur;
      chk($sformatf("sd p%0d", p), o_sd, e_sd);
      chk($sformatf("ws p%0d", p), o_ws, e_ws);
      chk($sformatf("busy p%0d", p), o_busy, 32'd1);
      chk($sformatf("underrun p%0d", p), o_underrun, e_ur);
      if (feed && p == 0) begin
        chk("ready_pos0", o_ready, 32'd1);
        i_left  = nl;
        i_right = nr;
        i_valid = 1'b1;
      end
      if (feed && p == 1) begin
        i_valid = 1'b0;
        chk("ready_after_accept", o_ready, 32'd0);
      end
      if (p == clr_at) i_clr_underrun = 1'b1;
      else if (p == clr_at + 1) i_clr_underrun = 1'b0;
      if (p == drop_at) i_enable = 1'b0;
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_ready);
    chk({tag, "_busy"}, o_busy, 32'd0);
    chk({tag, "_ws"}, o_ws, 32'd0);
    chk({tag, "_sd"}, o_sd, 32'd0);
    chk({tag, "_ready"}, o_ready, 32'(exp_ready));
  endtask

  initial begin
    // reset state
    tick();
    chk_idle("reset", 1'b1);
    chk("reset_underrun", o_underrun, 32'd0);
    tick();
    i_nrst = 1'b1;

    // basic frame, start latency with a full buffer
    i_left = 16'hA5C3; i_right = 16'h0F0F; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("ready_after_load", o_ready, 32'd0);
    chk("idle_busy", o_busy, 32'd0);
    i_enable = 1'b1;
    tick();
    chk("arm_busy", o_busy, 32'd1);
    chk("arm_sd", o_sd, 32'd0);
    chk("arm_ws", o_ws, 32'd0);
    tick();

    // back-to-back frames, each pair fed at pos 0
    check_frame(16'hA5C3, 16'h0F0F, 1'b0, -1, -1, 1'b1, 16'h1234, 16'h8001);
    tick();
    check_frame(16'h1234, 16'h8001, 1'b0, -1, -1, 1'b1, 16'hFFFF, 16'h0001);
    tick();
    check_frame(16'hFFFF, 16'h0001, 1'b0, -1, -1, 1'b1, 16'h8000, 16'h7FFE);
    tick();
    check_frame(16'h8000, 16'h7FFE, 1'b0, -1, -1, 1'b0, 16'h0000, 16'h0000);

    // underrun: clear held on the set edge must not win
    i_clr_underrun = 1'b1;
    tick();
    check_frame(16'h0000, 16'h0000, 1'b1, -1, -1, 1'b0, 16'h0000, 16'h0000);
    chk("ready_underrun_frame", o_ready, 32'd1);

    // later frame: clear at pos 5, stop at pos 10, pair buffered at pos 0
    tick();
    check_frame(16'h0000, 16'h0000, 1'b1, 5, 10, 1'b1, 16'hC3A5, 16'h5AA5);
    tick();
    chk_idle("stop", 1'b0);
    chk("stop_underrun", o_underrun, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("stop_hold", 1'b0);
    end

    // re-enable transmits the retained pair first
    i_enable = 1'b1;
    tick();
    chk("rearm_busy", o_busy, 32'd1);
    chk("rearm_sd", o_sd, 32'd0);
    tick();
    check_frame(16'hC3A5, 16'h5AA5, 1'b0, -1, 0, 1'b0, 16'h0000, 16'h0000);
    tick();
    chk_idle("after_retained", 1'b1);

    // ARM abort with the buffer empty
    i_enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort_busy", o_busy, 32'd1);
      chk("abort_ws", o_ws, 32'd0);
      chk("abort_sd", o_sd, 32'd0);
    end
    i_enable = 1'b0;
    tick();
    chk_idle("abort", 1'b1);

    // async reset at pos 40 with the buffer full
    i_left = 16'hDEAD; i_right = 16'h1111; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_enable = 1'b1;
    tick();
    tick();
    chk("rst_frame_msb", o_sd, 32'd1);
    i_left = 16'hBEEF; i_right = 16'hCAFE; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("rst_buf_full", o_ready, 32'd0);
    for (int i = 2; i <= 40; i++) tick();
    chk("rst_pos40_ws", o_ws, 32'd1);
    #2;
    i_nrst = 1'b0;
    #1;
    chk_idle("async_rst", 1'b1);
    chk("async_rst_underrun", o_underrun, 32'd0);
    i_enable = 1'b0;
    tick();
    i_nrst = 1'b1;
    i_left = 16'h6E01; i_right = 16'h0180; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_enable = 1'b1;
    tick();
    tick();
    check_frame(16'h6E01, 16'h0180, 1'b0, -1, 0, 1'b0, 16'h0000, 16'h0000);
    tick();
    chk_idle("final", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
